// File: rtl/btn_conditioner.sv
// Push-button front end: per-button 2-flop synchroniser, debouncer with level and
// press/release pulses, and optional auto-repeat of the press pulse while held.
module btn_conditioner #(
    parameter int N_BTN         = 4,
    parameter int DEBOUNCE_CYC  = 650000,
    parameter int REPEAT_DELAY  = 32500000,
    parameter int REPEAT_PERIOD = 9750000,
    parameter int CNT_W         = $clog2(
        (((DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY) > REPEAT_PERIOD
            ? ((DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY)
            : REPEAT_PERIOD) + 1)
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam bit             REP_EN   = (REPEAT_DELAY != 0);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] s;

    btn_state_t       state     [N_BTN];
    btn_state_t       state_nxt [N_BTN];
    logic [CNT_W-1:0] dcnt      [N_BTN];
    logic [CNT_W-1:0] dcnt_nxt  [N_BTN];
    logic [CNT_W-1:0] rcnt      [N_BTN];
    logic [CNT_W-1:0] rcnt_nxt  [N_BTN];
    logic [N_BTN-1:0] rep_first;
    logic [N_BTN-1:0] rep_first_nxt;
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] press_nxt;
    logic [N_BTN-1:0] release_nxt;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= btn_raw;
            s     <= sync1;
        end
    end

    // rep_first selects the initial repeat delay versus the steady repeat period.
    always_comb begin
        logic rep_due;
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt[i]     = state[i];
            dcnt_nxt[i]      = '0;
            rcnt_nxt[i]      = '0;
            rep_first_nxt[i] = rep_first[i];
            level_nxt[i]     = btn_level[i];
            press_nxt[i]     = 1'b0;
            release_nxt[i]   = 1'b0;
            rep_due          = REP_EN && (rep_first[i] ? (rcnt[i] == RD_LAST)
                                                       : (rcnt[i] == RP_LAST));
            case (state[i])
                RELEASED, PRESS_WAIT: begin
                    if (!s[i]) begin
                        state_nxt[i] = RELEASED;
                    end else if (dcnt[i] == DEB_LAST) begin
                        state_nxt[i]     = HELD;
                        level_nxt[i]     = 1'b1;
                        press_nxt[i]     = 1'b1;
                        rep_first_nxt[i] = 1'b1;
                    end else begin
                        state_nxt[i] = PRESS_WAIT;
                        dcnt_nxt[i]  = dcnt[i] + 1'b1;
                    end
                end
                HELD, RELEASE_WAIT: begin
                    if (!s[i] && dcnt[i] == DEB_LAST) begin
                        // A repeat pulse landing on the release edge is dropped.
                        state_nxt[i]   = RELEASED;
                        level_nxt[i]   = 1'b0;
                        release_nxt[i] = 1'b1;
                    end else begin
                        if (s[i]) begin
                            state_nxt[i] = HELD;
                        end else begin
                            state_nxt[i] = RELEASE_WAIT;
                            dcnt_nxt[i]  = dcnt[i] + 1'b1;
                        end
                        if (rep_due) begin
                            press_nxt[i]     = 1'b1;
                            rep_first_nxt[i] = 1'b0;
                        end else if (REP_EN) begin
                            rcnt_nxt[i] = rcnt[i] + 1'b1;
                        end
                    end
                end
                default: state_nxt[i] = RELEASED;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= RELEASED;
                dcnt[i]  <= '0;
                rcnt[i]  <= '0;
            end
            rep_first   <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= state_nxt[i];
                dcnt[i]  <= dcnt_nxt[i];
                rcnt[i]  <= rcnt_nxt[i];
            end
            rep_first   <= rep_first_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random button
// activity, compared every edge against a sliding-window reference model.
module tb_btn_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int HS = 4096;

    logic         pclk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    btn_conditioner #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (D),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: raw history per edge; a level change is accepted when the
    // synchronised value has differed from the level for the last D edges.
    logic [N-1:0] samp [HS];
    int           t = -1;
    int           e0 = 1 << 30;
    int           rst_events = 0;
    int           rst_seen = 0;
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel = '0;
    int           m_p [N];
    logic         mv;
    int           mk;

    always @(posedge rst) rst_events++;

    function automatic logic s_at(input int tt, input int i);
        if (tt < 2 || tt - 2 < e0) return 1'b0;
        return samp[(tt - 2) % HS][i];
    endfunction

    function automatic logic stable_window(input int tt, input int i, input logic v);
        for (int j = 0; j < D; j++) begin
            if (tt - j < e0 || s_at(tt - j, i) !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge pclk) begin
        t++;
        samp[t % HS] = btn_raw;
        if (rst) begin
            rst_seen = rst_events;
            e0       = t + 1;
            m_level  = '0;
            m_press  = '0;
            m_rel    = '0;
        end else begin
            if (rst_events != rst_seen) begin
                rst_seen = rst_events;
                e0       = t;
                m_level  = '0;
            end
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < N; i++) begin
                mv = s_at(t, i);
                if (mv != m_level[i] && stable_window(t, i, mv)) begin
                    m_level[i] = mv;
                    if (mv) begin
                        m_press[i] = 1'b1;
                        m_p[i]     = t;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                end else if (m_level[i]) begin
                    mk = t - m_p[i];
                    if (mk == RD || (mk > RD && (mk - RD) % RP == 0)) m_press[i] = 1'b1;
                end
            end
        end
        #1;
        checkOutput("model_level", btn_level, m_level);
        checkOutput("model_press", btn_press, m_press);
        checkOutput("model_release", btn_release, m_rel);
    end

    task automatic applyStimulus(input logic [N-1:0] val, input int hold);
        @(negedge pclk);
        btn_raw = val;
        repeat (hold - 1) @(negedge pclk);
    endtask

    // Drive a new raw value and check the pulse lands exactly D+1 edges after first sample.
    task automatic pressAndCheck(input logic [N-1:0] val, input string tag,
                                 input logic [N-1:0] exp_press, input logic [N-1:0] exp_rel);
        @(negedge pclk);
        btn_raw = val;
        repeat (D + 1) @(posedge pclk);
        #1;
        checkOutput({tag, "_early"}, btn_press | btn_release, '0);
        @(posedge pclk);
        #1;
        checkOutput({tag, "_press"}, btn_press, exp_press);
        checkOutput({tag, "_release"}, btn_release, exp_rel);
        @(posedge pclk);
        #1;
        checkOutput({tag, "_width"}, btn_press | btn_release, '0);
    endtask

    task automatic pulseReset(input int offset);
        @(posedge pclk);
        #(offset);
        rst = 1'b1;
        #1;
        checkOutput("rst_level", btn_level, '0);
        checkOutput("rst_press", btn_press, '0);
        checkOutput("rst_release", btn_release, '0);
        @(negedge pclk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [N-1:0] flip;
        int hold;
        btn_raw = '0;
        rst     = 1'b1;
        repeat (3) @(negedge pclk);
        checkOutput("reset_level", btn_level, '0);
        checkOutput("reset_press", btn_press, '0);
        btn_raw = 4'b1111;
        #1;
        checkOutput("reset_ignores_raw", btn_level, '0);
        @(negedge pclk);
        btn_raw = '0;
        rst     = 1'b0;
        applyStimulus('0, 3);

        $display("[TB] clean press");
        pressAndCheck(4'b0100, "t1", 4'b0100, 4'b0000);
        checkOutput("t1_level", btn_level, 4'b0100);

        $display("[TB] release");
        pressAndCheck(4'b0000, "t3", 4'b0000, 4'b0100);
        checkOutput("t3_level", btn_level, 4'b0000);

        $display("[TB] bounce");
        applyStimulus(4'b0001, 2);
        applyStimulus(4'b0000, 2);
        applyStimulus(4'b0001, 2);
        applyStimulus(4'b0000, 2);
        pressAndCheck(4'b0001, "t2", 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 12);

        $display("[TB] auto-repeat");
        @(negedge pclk);
        btn_raw = 4'b0010;
        cnt = 0;
        repeat (44) begin
            @(posedge pclk);
            #1;
            if (btn_press[1]) cnt++;
        end
        checkOutput("t4_repeat_count", cnt, 4);
        @(negedge pclk);
        btn_raw = 4'b0000;
        repeat (6) @(posedge pclk);
        #1;
        checkOutput("t4_suppressed_press", btn_press, 4'b0000);
        checkOutput("t4_release", btn_release, 4'b0010);
        applyStimulus(4'b0000, 30);

        $display("[TB] simultaneous");
        pressAndCheck(4'b1001, "t5", 4'b1001, 4'b0000);
        applyStimulus(4'b1000, 10);

        $display("[TB] reset mid-hold");
        pulseReset(3);
        repeat (D + 1) @(posedge pclk);
        #1;
        checkOutput("t6_early", btn_press, 4'b0000);
        @(posedge pclk);
        #1;
        checkOutput("t6_press", btn_press, 4'b1000);
        checkOutput("t6_level", btn_level, 4'b1000);
        applyStimulus(4'b0000, 10);

        $display("[TB] random activity");
        for (int it = 0; it < 220; it++) begin
            flip = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 8));
            applyStimulus(btn_raw ^ flip, hold);
            if ($urandom_range(0, 39) == 0) pulseReset(int'($urandom_range(2, 4)));
        end
        applyStimulus('0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
